// File: rtl/pipe_ctrl.sv
// Pipeline controller: tracks per-stage valid/destination state, blocks issue on register
// hazards via a pending-write scoreboard, holds the front of the pipe on a slow memory stage.
module pipe_ctrl #(
  parameter int STAGES      = 5,
  parameter int REGAW       = 4,
  parameter int MEM_STAGE   = 3,
  parameter int FLUSH_STAGE = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              issue_we,
  input  logic [REGAW-1:0]  issue_rd_a,
  input  logic [REGAW-1:0]  issue_rn_a,
  input  logic [REGAW-1:0]  issue_rm_a,
  input  logic              issue_use_rn,
  input  logic              issue_use_rm,
  input  logic              mem_ready,
  input  logic              flush,
  output logic [STAGES-1:0] stage_valid,
  output logic [STAGES-1:0] stage_en,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REGAW-1:0]  wb_rd_a,
  output logic              hazard
);

  localparam int NREG = 2 ** REGAW;

  logic [NREG-1:0]   pend_q;
  logic [NREG-1:0]   pend_nxt;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_nxt;
  logic [STAGES-1:0] we_q;
  logic [STAGES-1:0] we_nxt;
  logic [STAGES-1:0] live;
  logic [REGAW-1:0]  rd_q   [STAGES];
  logic [REGAW-1:0]  rd_nxt [STAGES];
  logic              stall;
  logic              flush_eff;

  always_comb begin
    hazard      = issue_valid & ((issue_use_rn & pend_q[issue_rn_a]) |
                                 (issue_use_rm & pend_q[issue_rm_a]) |
                                 (issue_we & pend_q[issue_rd_a]));
    stall       = valid_q[MEM_STAGE] & ~mem_ready;
    flush_eff   = flush & valid_q[FLUSH_STAGE];
    issue_ready = issue_valid & ~hazard & ~stall & ~flush_eff;
    for (int i = 0; i < STAGES; i++) begin
      stage_en[i] = valid_q[i] & ~(stall & (i <= MEM_STAGE));
      // Killed stages are masked before the shift so their content never reaches FLUSH_STAGE.
      live[i]     = valid_q[i] & ~(flush_eff & (i < FLUSH_STAGE));
    end
  end

  always_comb begin
    valid_nxt = '0;
    we_nxt    = '0;
    for (int i = 0; i < STAGES; i++) rd_nxt[i] = rd_q[i];
    if (stall) begin
      valid_nxt[0] = live[0];
      we_nxt[0]    = we_q[0] & live[0];
    end else begin
      valid_nxt[0] = issue_ready;
      we_nxt[0]    = issue_ready & issue_we;
      rd_nxt[0]    = issue_ready ? issue_rd_a : '0;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (stall && i <= MEM_STAGE) begin
        valid_nxt[i] = live[i];
        we_nxt[i]    = we_q[i] & live[i];
      end else if (stall && i == MEM_STAGE + 1) begin
        valid_nxt[i] = 1'b0;
        we_nxt[i]    = 1'b0;
        rd_nxt[i]    = '0;
      end else begin
        valid_nxt[i] = live[i-1];
        we_nxt[i]    = we_q[i-1] & live[i-1];
        rd_nxt[i]    = rd_q[i-1];
      end
    end
  end

  // Set is applied last so a same-cycle set and clear of one register leaves it pending.
  always_comb begin
    pend_nxt = pend_q;
    if (wb_valid && wb_we) pend_nxt[wb_rd_a] = 1'b0;
    for (int i = 0; i < FLUSH_STAGE; i++) begin
      if (flush_eff && valid_q[i] && we_q[i]) pend_nxt[rd_q[i]] = 1'b0;
    end
    if (issue_ready && issue_we) pend_nxt[issue_rd_a] = 1'b1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pend_q  <= '0;
      valid_q <= '0;
      we_q    <= '0;
      for (int i = 0; i < STAGES; i++) rd_q[i] <= '0;
    end else begin
      pend_q  <= pend_nxt;
      valid_q <= valid_nxt;
      we_q    <= we_nxt;
      for (int i = 0; i < STAGES; i++) rd_q[i] <= rd_nxt[i];
    end
  end

  assign stage_valid = valid_q;
  assign wb_valid    = valid_q[STAGES-1];
  assign wb_we       = valid_q[STAGES-1] & we_q[STAGES-1];
  assign wb_rd_a     = rd_q[STAGES-1];

endmodule
